sha3_padder: RTL and testbench

SHA3_PADDER -- requirements
Module: sha3_padder

---
 rtl/sha3_padder.sv | 116 +++++++++++
 tb/tb_sha3_padder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/sha3_padder.sv
// SHA-3 rate-block padder: packs 64-bit message words into R_BLOCK_SIZE-bit blocks and applies pad10*1
// with the domain byte. Define SHA3_PADDER_SHAKE_EN to use the SHAKE domain byte (0x1F) instead of SHA3 (0x06).
module sha3_padder #(
  parameter int R_BLOCK_SIZE = 1088
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [0:63]             in_data,
  input  logic [3:0]              in_bytes,
  input  logic                    in_valid,
  input  logic                    in_last,
  output logic                    in_ready,
  output logic [0:R_BLOCK_SIZE-1] out_block,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_last
);

  localparam int NW = R_BLOCK_SIZE / 64;
  localparam int NB = R_BLOCK_SIZE / 8;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;

`ifdef SHA3_PADDER_SHAKE_EN
  localparam logic [7:0] DOMAIN = 8'h1F;
`else
  localparam logic [7:0] DOMAIN = 8'h06;
`endif

  typedef enum logic {FILL, FULL} state_t;

  state_t                  state;
  logic [WW-1:0]           w;
  logic                    extra;
  logic [3:0]              n_bytes;
  logic                    last_slot;
  logic                    need_extra;
  logic [0:R_BLOCK_SIZE-1] fill_block;
  logic [0:R_BLOCK_SIZE-1] pad_block;

  // Ready is gated by reset so no word can be offered as accepted while the block is being cleared.
  assign in_ready = (state == FILL) && rst_n;

  // NOTE: every variable in this always_comb gets a default first so no latch is inferred.
  always_comb begin
    int k;
    int base;
    fill_block = out_block;
    pad_block  = '0;
    n_bytes    = (in_bytes > 4'd8) ? 4'd8 : in_bytes;
    last_slot  = (int'(w) == NW - 1);
    need_extra = in_last && (n_bytes == 4'd8) && last_slot;
    base       = 8 * int'(w);
    k          = 0;
    // The buffer beyond the current slot is always zero, so only data, D and 0x80 need writing.
    for (int j = 0; j < NB; j++) begin
      if (j >= base && j < base + 8) begin
        k = j - base;
        if (!in_last || k < int'(n_bytes))
          fill_block[8*j +: 8] = in_data[8*k +: 8];
      end
      if (in_last && !need_extra && j == base + int'(n_bytes))
        fill_block[8*j +: 8] = DOMAIN;
    end
    if (in_last && !need_extra)
      fill_block[R_BLOCK_SIZE-8 +: 8] = fill_block[R_BLOCK_SIZE-8 +: 8] | 8'h80;
    pad_block[0:7]                 = DOMAIN;
    pad_block[R_BLOCK_SIZE-8 +: 8] = pad_block[R_BLOCK_SIZE-8 +: 8] | 8'h80;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the block buffer is reset because a discarded partial message must never leak into the next one.
      state     <= FILL;
      w         <= '0;
      extra     <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_block <= '0;
    end else begin
      case (state)
        FILL: begin
          if (in_valid) begin
            out_block <= fill_block;
            if (in_last || last_slot) begin
              state     <= FULL;
              out_valid <= 1'b1;
              out_last  <= in_last && !need_extra;
              extra     <= need_extra;
              w         <= '0;
            end else begin
              w <= w + WW'(1);
            end
          end
        end
        FULL: begin
          if (out_ready) begin
            if (extra) begin
              out_block <= pad_block;
              out_last  <= 1'b1;
              extra     <= 1'b0;
            end else begin
              state     <= FILL;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              out_block <= '0;
              w         <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_sha3_padder.sv
// Self-checking bench for sha3_padder (rate 1088, SHA3 domain): a pad10*1 byte model fills a scoreboard
// queue when each message is sent; blocks are popped and compared as the DUT presents them.
module tb_sha3_padder;

  localparam int R  = 1088;
  localparam int NB = R / 8;
  localparam int NW = R / 64;
  localparam logic [7:0] D = 8'h06;

  typedef struct {
    logic [0:R-1] blk;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [0:63]  in_data;
  logic [3:0]   in_bytes;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic [0:R-1] out_block;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;

  int   tests = 0;
  int   fails = 0;
  exp_t exp_q[$];
  logic [7:0] msg [0:511];

  sha3_padder #(.R_BLOCK_SIZE(R)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_bytes(in_bytes),
    .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .out_block(out_block), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [R-1:0] got, input logic [R-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference pad10*1: message || D || 0* || 0x80 over whole rate blocks.
  task automatic push_expected(input int len);
    int   nblk;
    logic [7:0] p [0:1023];
    exp_t e;
    nblk = len / NB + 1;
    for (int i = 0; i < nblk * NB; i++) p[i] = (i < len) ? msg[i] : 8'h00;
    p[len] = D;
    p[nblk*NB-1] = p[nblk*NB-1] | 8'h80;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < NB; j++) e.blk[8*j +: 8] = p[b*NB + j];
      e.last = (b == nblk - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send_word(input logic [0:63] data, input logic [3:0] nb, input logic last);
    int t;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) check("in_ready_timeout", 0, 1);
    in_data  = data;
    in_bytes = nb;
    in_last  = last;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Waits for a block, compares it with the scoreboard head, optionally holds back-pressure, then accepts it.
  task automatic check_block(input int hold);
    int   t;
    exp_t e;
    logic [0:R-1] held;
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      check("out_valid_timeout", 0, 1);
    end else if (exp_q.size() == 0) begin
      check("unexpected_block", 1, 0);
    end else begin
      e = exp_q.pop_front();
      check("out_block", out_block, e.blk);
      check("out_last", R'(out_last), R'(e.last));
      held = out_block;
      for (int c = 0; c < hold; c++) begin
        @(negedge clk);
        check("bp_valid", R'(out_valid), 1);
        check("bp_in_ready", R'(in_ready), 0);
        check("bp_block", out_block, held);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic send_msg(input int len, input int hold, input logic [3:0] full_code);
    int words;
    int nb;
    logic [0:63] d;
    push_expected(len);
    words = (len == 0) ? 1 : (len + 7) / 8;
    for (int i = 0; i < words; i++) begin
      nb = (i == words - 1) ? len - 8 * i : 8;
      d = {$urandom, $urandom};
      for (int k = 0; k < nb; k++) d[8*k +: 8] = msg[8*i + k];
      send_word(d, (i == words - 1 && nb == 8) ? full_code : 4'(nb), i == words - 1);
      if ((i % NW) == NW - 1 || i == words - 1) check_block(hold);
    end
    while (exp_q.size() > 0) check_block(0);
  endtask

  task automatic rand_msg(input int len);
    for (int i = 0; i < len; i++) msg[i] = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_in_ready", R'(in_ready), 0);
    @(negedge clk);
    check("rst_in_ready2", R'(in_ready), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", R'(out_valid), 0);
    check("rst_out_last", R'(out_last), 0);
    check("rst_out_block", out_block, '0);
    check("rst_in_ready_after", R'(in_ready), 1);
  endtask

  initial begin
    rst_n = 1'b0; in_data = '0; in_bytes = '0; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    do_reset();

    // Empty message.
    send_msg(0, 0, 4'd8);

    // "abc".
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0, 4'd8);

    // 136 bytes: data block without padding, then a pad-only block.
    rand_msg(136);
    send_msg(136, 0, 4'd8);

    // 135 bytes: D and 0x80 share the final byte.
    rand_msg(135);
    send_msg(135, 0, 4'd8);

    // Back-pressure for 10 cycles.
    rand_msg(20);
    send_msg(20, 10, 4'd8);

    // Full last word outside the final slot, with in_bytes above 8 clamped.
    rand_msg(16);
    send_msg(16, 0, 4'd15);

    // Multi-block message.
    rand_msg(300);
    send_msg(300, 2, 4'd8);

    // Reset after 5 accepted words, then "abc" must come out clean.
    for (int i = 0; i < 5; i++) send_word({$urandom, $urandom}, 4'd8, 1'b0);
    do_reset();
    msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    send_msg(3, 0, 4'd8);

    // Reset while a finished block is held: it must be dropped.
    send_word({$urandom, $urandom}, 4'd5, 1'b1);
    @(negedge clk);
    check("hold_before_reset", R'(out_valid), 1);
    do_reset();
    repeat (3) @(negedge clk);
    check("no_emit_after_reset", R'(out_valid), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
